sha_round_sequencer: RTL

Initiator side of the round-counter start/done protocol in the SHA-512 core. Accepts one message block from upstream, issues `cnt_start` pulses to the 5-bit round counter (`up_counter`), tracks counter passes to produce a global round index for the datapath, and presents a result handshake downstream. Also handles abort, drains a mid-count counter, and runs a watchdog on a missing `done`.

---
 rtl/sha_ctrl_pkg.sv | 16 +
 rtl/sha_round_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/sha_ctrl_pkg.sv
// Shared constants and FSM state type for the SHA-512 round control blocks.
package sha_ctrl_pkg;

  localparam int CNT_W           = 5;
  localparam int ROUNDS_PER_PASS = 32;
  localparam int DEFAULT_TIMEOUT = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_OUT,
    ST_DRAIN
  } seq_state_t;

endpackage

// File: rtl/sha_round_sequencer.sv
// Round sequencer: takes one block, drives PASSES start/done rounds on the
// 5-bit round counter, publishes {pass, cnt_value} and hands the result downstream.
module sha_round_sequencer
  import sha_ctrl_pkg::*;
#(
  parameter int PASSES  = 3,
  parameter int PASS_W  = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  output logic                    cnt_start,
  input  logic [CNT_W-1:0]        cnt_value,
  input  logic                    cnt_done,
  output logic                    round_active,
  output logic [PASS_W+CNT_W-1:0] round_idx,
  output logic                    res_valid,
  input  logic                    res_ready,
  input  logic                    abort,
  output logic                    busy,
  output logic                    err,
  output seq_state_t              state_dbg
);

  localparam int                WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  // Handshakes: a block transfers on a rising edge where blk_valid && blk_ready;
  // a result transfers on a rising edge where res_valid && res_ready. res_valid
  // never drops without a transfer except on abort or reset.

  seq_state_t        state;
  logic [PASS_W-1:0] pass;
  logic [WD_W-1:0]   wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pass      <= '0;
      wd        <= '0;
      blk_ready <= 1'b1;
      cnt_start <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (blk_valid && !abort) begin
            state     <= ST_START;
            pass      <= '0;
            blk_ready <= 1'b0;
            cnt_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          // The pulse is already out, so an abort here must still wait for done.
          cnt_start <= 1'b0;
          wd        <= '0;
          state     <= abort ? ST_DRAIN : ST_RUN;
        end
        ST_RUN: begin
          wd <= wd + 1'b1;
          if (abort) begin
            state <= ST_DRAIN;
            wd    <= '0;
          end else if (cnt_done) begin
            if (pass == LAST_PASS) begin
              state     <= ST_OUT;
              res_valid <= 1'b1;
            end else begin
              pass      <= pass + 1'b1;
              state     <= ST_START;
              cnt_start <= 1'b1;
            end
          end else if (wd == WD_LAST) begin
            state <= ST_DRAIN;
            wd    <= '0;
            err   <= 1'b1;
          end
        end
        ST_OUT: begin
          if (abort || res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_DRAIN: begin
          wd <= wd + 1'b1;
          if (cnt_done || (wd == WD_LAST)) begin
            state     <= ST_IDLE;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            if (!cnt_done) err <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          blk_ready <= 1'b1;
          cnt_start <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Index is gated so it reads zero whenever the counter value is not a live round.
  assign round_active = (state == ST_RUN) && !cnt_done;
  assign round_idx    = round_active ? {pass, cnt_value} : '0;
  assign state_dbg    = state;

endmodule
